uart_tx_seq: RTL and testbench

- Register-bus master that streams a byte block into the UART TX FIFO without CPU polling.
- Sits between a byte source (DMA or boot logic) and the UART register port.
- Reads the TX free-space register (addr 7), then issues up to that many writes to the TX data register (addr 5).
- Repeats until the programmed length is sent or the transfer is aborted.

---
 rtl/uart_tx_seq_if.sv | 23 ++
 rtl/uart_tx_seq.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_seq_if.sv
// Register-bus and source-byte signals between uart_tx_seq, the UART register port and the byte source.
interface uart_tx_seq_if;
  logic       reg_cs;
  logic       reg_wr;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_be;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, src_ready,
    input  reg_rdata, reg_ack, src_valid, src_data
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, src_ready,
    output reg_rdata, reg_ack, src_valid, src_data
  );
endinterface

// File: rtl/uart_tx_seq.sv
// Streams a byte block into the UART TX FIFO: polls free space, then writes up to that many bytes.
// First cs one cycle after cmd_start; cs held until reg_ack, then at least one idle cycle; source stalls idle the bus.
module uart_tx_seq #(
  parameter int         LEN_W       = 16,
  parameter int         POLL_DLY    = 8,
  parameter logic [3:0] ADDR_FSPACE = 4'h7,
  parameter logic [3:0] ADDR_TXDATA = 4'h5
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] sent_cnt,
  uart_tx_seq_if.master    bus
);
  localparam int            PW        = (POLL_DLY > 1) ? $clog2(POLL_DLY) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DLY - 1);

  typedef enum logic [2:0] {IDLE, RD_SP, WR_WAIT, WR_BUS, POLL, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_d, done_d, aborted_d;
  logic             abort_pend_q, abort_pend_d;
  logic [LEN_W-1:0] sent_d, rem_q, rem_d;
  logic [4:0]       burst_q, burst_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             cs_q, cs_d, wr_q, wr_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             ack, abort_now;
  logic [4:0]       space;
  logic             rdata_unused;

  assign ack          = cs_q & bus.reg_ack;
  assign abort_now    = abort_pend_q | cmd_abort;
  assign space        = bus.reg_rdata[4:0];
  assign rdata_unused = ^bus.reg_rdata[7:5];

  always_comb begin
    state_d      = state_q;
    busy_d       = busy;
    done_d       = 1'b0;
    aborted_d    = aborted;
    sent_d       = sent_cnt;
    rem_d        = rem_q;
    burst_d      = burst_q;
    pcnt_d       = pcnt_q;
    abort_pend_d = abort_pend_q | (cmd_abort && (state_q != IDLE));
    cs_d         = cs_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (cmd_start) begin
          aborted_d = 1'b0;
          sent_d    = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = cmd_len;
            busy_d  = 1'b1;
            cs_d    = 1'b1;
            wr_d    = 1'b0;
            addr_d  = ADDR_FSPACE;
            state_d = RD_SP;
          end
        end
      end
      RD_SP: begin
        // Entered with cs low after a burst, so the read starts one cycle later.
        if (!cs_q) begin
          cs_d   = 1'b1;
          wr_d   = 1'b0;
          addr_d = ADDR_FSPACE;
        end else if (ack) begin
          cs_d = 1'b0;
          if (abort_now) begin
            done_d    = 1'b1;
            aborted_d = 1'b1;
            state_d   = DONE;
          end else if (space == 5'd0) begin
            pcnt_d  = '0;
            state_d = POLL;
          end else begin
            burst_d = (rem_q < LEN_W'(space)) ? rem_q[4:0] : space;
            state_d = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (abort_now) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (bus.src_valid) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ADDR_TXDATA;
          wdata_d = bus.src_data;
          state_d = WR_BUS;
        end
      end
      WR_BUS: begin
        if (ack) begin
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          sent_d  = sent_cnt + LEN_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          burst_d = burst_q - 5'd1;
          // The last byte wins over a coincident abort.
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (abort_now) begin
            done_d    = 1'b1;
            aborted_d = 1'b1;
            state_d   = DONE;
          end else if (burst_q == 5'd1) begin
            state_d = RD_SP;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end
      POLL: begin
        if (abort_now) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (pcnt_q == POLL_LAST) begin
          cs_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = ADDR_FSPACE;
          state_d = RD_SP;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      DONE: begin
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      sent_cnt     <= '0;
      rem_q        <= '0;
      burst_q      <= '0;
      pcnt_q       <= '0;
      abort_pend_q <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy         <= busy_d;
      done         <= done_d;
      aborted      <= aborted_d;
      sent_cnt     <= sent_d;
      rem_q        <= rem_d;
      burst_q      <= burst_d;
      pcnt_q       <= pcnt_d;
      abort_pend_q <= abort_pend_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.reg_cs    = cs_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = cs_q;
  assign bus.src_ready = (state_q == WR_BUS) & ack;
endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: register-slave and byte-source models with an expected-byte scoreboard.
module tb_uart_tx_seq;
  localparam int LEN_W    = 16;
  localparam int POLL_DLY = 8;

  logic             mclk = 1'b0;
  logic             reset;
  logic             cmd_start;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_abort;
  logic             busy, done, aborted;
  logic [LEN_W-1:0] sent_cnt;

  uart_tx_seq_if bus ();

  uart_tx_seq #(
    .LEN_W(LEN_W), .POLL_DLY(POLL_DLY), .ADDR_FSPACE(4'h7), .ADDR_TXDATA(4'h5)
  ) dut (
    .mclk(mclk), .reset(reset), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_abort(cmd_abort), .busy(busy), .done(done), .aborted(aborted),
    .sent_cnt(sent_cnt), .bus(bus)
  );

  always #5 mclk = ~mclk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] space_q[$];
  int         log_wr[$];
  int         log_gap[$];
  int         done_cnt = 0;
  int         wr_started = 0;
  int         pop_cnt = 0;
  int         pop_base = 0;
  int         gap = 0;
  int         held_gap = 0;
  bit         seen = 0;
  logic       held_wr;
  logic [3:0] held_addr;
  logic [7:0] held_wdata;

  // Register slave: acks in the second cs-high cycle, answers reads from space_q, scores writes.
  task automatic bus_monitor();
    logic [7:0] e;
    forever begin
      @(negedge mclk);
      if (done === 1'b1) done_cnt++;
      if (bus.reg_ack === 1'b1) begin
        checks++;
        if (bus.reg_cs !== 1'b0) begin
          errors++; $display("FAIL cs_drop: cs=%b one cycle after ack, want 0", bus.reg_cs);
        end
        bus.reg_ack = 1'b0; seen = 0; gap = 1;
      end else if (bus.reg_cs === 1'b1) begin
        checks++;
        if (bus.reg_be !== 1'b1) begin
          errors++; $display("FAIL reg_be: got %b, want 1 while cs high", bus.reg_be);
        end
        if (!seen) begin
          seen = 1; held_wr = bus.reg_wr; held_addr = bus.reg_addr;
          held_wdata = bus.reg_wdata; held_gap = gap;
          if (bus.reg_wr === 1'b1) wr_started++;
        end else begin
          checks++;
          if ({bus.reg_wr, bus.reg_addr, bus.reg_wdata} !== {held_wr, held_addr, held_wdata}) begin
            errors++; $display("FAIL bus_hold: got %h, want %h", {bus.reg_wr, bus.reg_addr, bus.reg_wdata},
                               {held_wr, held_addr, held_wdata});
          end
          bus.reg_ack = 1'b1;
          log_wr.push_back(int'(held_wr)); log_gap.push_back(held_gap);
          if (held_wr) begin
            checks++;
            if (held_addr !== 4'h5) begin
              errors++; $display("FAIL wr_addr: got %h, want 5", held_addr);
            end
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL wr_data: got %h, want no write", held_wdata);
            end else begin
              e = exp_q.pop_front();
              if (held_wdata !== e) begin
                errors++; $display("FAIL wr_data: got %h, want %h", held_wdata, e);
              end
            end
          end else begin
            checks++;
            if (held_addr !== 4'h7) begin
              errors++; $display("FAIL rd_addr: got %h, want 7", held_addr);
            end
            bus.reg_rdata = (space_q.size() != 0) ? space_q.pop_front() : 8'd16;
          end
        end
        gap = 0;
      end else begin
        seen = 0; gap++;
      end
    end
  endtask

  // Byte source: counts pops in the ack cycle and presents 0x41 + bytes popped this transfer.
  task automatic byte_source();
    forever begin
      @(negedge mclk); #2;
      if (bus.src_ready === 1'b1) pop_cnt++;
      bus.src_data = 8'h41 + 8'(pop_cnt - pop_base);
    end
  endtask

  function automatic int count_kind(input int kind);
    int n = 0;
    foreach (log_wr[i]) if (log_wr[i] == kind) n++;
    return n;
  endfunction

  task automatic new_transfer(input int nbytes);
    log_wr.delete(); log_gap.delete(); exp_q.delete();
    for (int i = 0; i < nbytes; i++) exp_q.push_back(8'h41 + 8'(i));
    pop_base = pop_cnt;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] len);
    @(negedge mclk); cmd_len = len; cmd_start = 1'b1;
    @(negedge mclk); cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge mclk); #1; n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++; $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_start = 1'b0; cmd_len = '0; cmd_abort = 1'b0;
    bus.src_valid = 1'b1; bus.src_data = 8'h41; bus.reg_ack = 1'b0; bus.reg_rdata = 8'h00;
    repeat (3) @(negedge mclk);
    checks++;
    if ({busy, done, aborted, sent_cnt} !== '0) begin
      errors++; $display("FAIL reset_status: got %h, want 0", {busy, done, aborted, sent_cnt});
    end
    checks++;
    if ({bus.reg_cs, bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.reg_be, bus.src_ready} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h, want 0",
                         {bus.reg_cs, bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.reg_be, bus.src_ready});
    end
    reset = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    new_transfer(5); space_q.push_back(8'd16);
    pulse_start(16'd5);
    checks++;
    if (bus.reg_cs !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL start_latency: cs=%b busy=%b, want 1 1", bus.reg_cs, busy);
    end
    wait_done(200);
    repeat (5) @(negedge mclk); #1;
    checks++;
    if (count_kind(0) != 1 || count_kind(1) != 5) begin
      errors++; $display("FAIL basic_accesses: reads=%0d writes=%0d, want 1 5", count_kind(0), count_kind(1));
    end
    checks++;
    if (log_gap.size() < 2 || log_gap[1] != 1) begin
      errors++; $display("FAIL first_write_latency: gap=%0d, want 1", (log_gap.size() > 1) ? log_gap[1] : -1);
    end
    checks++;
    if (sent_cnt !== 16'd5 || aborted !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_status: sent=%0d aborted=%b busy=%b, want 5 0 0", sent_cnt, aborted, busy);
    end
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0 || pop_cnt - pop_base != 5) begin
      errors++; $display("FAIL basic_counts: dones=%0d left=%0d pops=%0d, want 1 0 5",
                         done_cnt - d0, exp_q.size(), pop_cnt - pop_base);
    end
  endtask

  task automatic test_refill();
    new_transfer(20); space_q.push_back(8'd16); space_q.push_back(8'd4);
    pulse_start(16'd20);
    wait_done(400);
    repeat (3) @(negedge mclk); #1;
    checks++;
    if (count_kind(0) != 2 || count_kind(1) != 20 || log_wr.size() < 18 || log_wr[17] != 0) begin
      errors++; $display("FAIL refill_accesses: reads=%0d writes=%0d, want 2 20 with re-read after 16",
                         count_kind(0), count_kind(1));
    end
    checks++;
    if (sent_cnt !== 16'd20 || exp_q.size() != 0) begin
      errors++; $display("FAIL refill_status: sent=%0d left=%0d, want 20 0", sent_cnt, exp_q.size());
    end
  endtask

  task automatic test_poll();
    new_transfer(3);
    space_q.push_back(8'd0); space_q.push_back(8'd0); space_q.push_back(8'd3);
    pulse_start(16'd3);
    wait_done(400);
    repeat (3) @(negedge mclk); #1;
    checks++;
    if (log_wr.size() != 6 || count_kind(0) != 3 || log_wr[2] != 0) begin
      errors++; $display("FAIL poll_accesses: total=%0d reads=%0d, want 6 3", log_wr.size(), count_kind(0));
    end
    checks++;
    if (log_gap.size() < 3 || log_gap[1] != POLL_DLY || log_gap[2] != POLL_DLY) begin
      errors++; $display("FAIL poll_gap: gaps=%0d,%0d want %0d", (log_gap.size() > 1) ? log_gap[1] : -1,
                         (log_gap.size() > 2) ? log_gap[2] : -1, POLL_DLY);
    end
    checks++;
    if (sent_cnt !== 16'd3 || exp_q.size() != 0) begin
      errors++; $display("FAIL poll_status: sent=%0d left=%0d, want 3 0", sent_cnt, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int w0 = wr_started;
    int n  = 0;
    int l0;
    new_transfer(10); space_q.push_back(8'd16);
    pulse_start(16'd10);
    while (wr_started - w0 < 3 && n < 200) begin
      @(negedge mclk); #1; n++;
    end
    cmd_abort = 1'b1;
    @(negedge mclk); cmd_abort = 1'b0;
    wait_done(100);
    l0 = log_wr.size();
    repeat (10) @(negedge mclk); #1;
    checks++;
    if (aborted !== 1'b1 || sent_cnt !== 16'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_status: aborted=%b sent=%0d busy=%b, want 1 3 0", aborted, sent_cnt, busy);
    end
    checks++;
    if (count_kind(1) != 3 || log_wr.size() != l0 || exp_q.size() != 7 || pop_cnt - pop_base != 3) begin
      errors++; $display("FAIL abort_bus: writes=%0d extra=%0d left=%0d pops=%0d, want 3 0 7 3",
                         count_kind(1), log_wr.size() - l0, exp_q.size(), pop_cnt - pop_base);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    new_transfer(0);
    pulse_start(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: done=%b busy=%b aborted=%b, want 1 0 0", done, busy, aborted);
    end
    repeat (5) @(negedge mclk); #1;
    checks++;
    if (log_wr.size() != 0 || done_cnt - d0 != 1 || sent_cnt !== '0) begin
      errors++; $display("FAIL zero_len_bus: accesses=%0d dones=%0d sent=%0d, want 0 1 0",
                         log_wr.size(), done_cnt - d0, sent_cnt);
    end
  endtask

  task automatic test_stall();
    int n  = 0;
    int bad = 0;
    new_transfer(6); space_q.push_back(8'd16);
    pulse_start(16'd6);
    while (count_kind(1) < 2 && n < 200) begin
      @(negedge mclk); #1; n++;
    end
    @(negedge mclk); #1;
    bus.src_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge mclk); #1;
      if (bus.reg_cs !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_cs: cs high in %0d stall cycles, want 0", bad);
    end
    bus.src_valid = 1'b1;
    wait_done(200);
    repeat (3) @(negedge mclk); #1;
    checks++;
    if (count_kind(1) != 6 || exp_q.size() != 0 || pop_cnt - pop_base != 6 || sent_cnt !== 16'd6) begin
      errors++; $display("FAIL stall_data: writes=%0d left=%0d pops=%0d sent=%0d, want 6 0 6 6",
                         count_kind(1), exp_q.size(), pop_cnt - pop_base, sent_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_started;
    int n  = 0;
    int d0;
    new_transfer(8); space_q.push_back(8'd16);
    pulse_start(16'd8);
    while (wr_started - w0 < 2 && n < 200) begin
      @(negedge mclk); #1; n++;
    end
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge mclk); #1;
    checks++;
    if ({busy, done, aborted, sent_cnt, bus.reg_cs, bus.reg_wr, bus.reg_addr, bus.reg_wdata,
         bus.reg_be, bus.src_ready} !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b sent=%0d cs=%b wr=%b, want all 0",
                         busy, done, sent_cnt, bus.reg_cs, bus.reg_wr);
    end
    @(negedge mclk); reset = 1'b0;
    repeat (3) @(negedge mclk); #1;
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL reset_no_done: dones=%0d, want 0", done_cnt - d0);
    end
    space_q.delete();
    new_transfer(2); space_q.push_back(8'd16);
    pulse_start(16'd2);
    wait_done(200);
    repeat (3) @(negedge mclk); #1;
    checks++;
    if (sent_cnt !== 16'd2 || count_kind(1) != 2 || exp_q.size() != 0 || aborted !== 1'b0) begin
      errors++; $display("FAIL reset_restart: sent=%0d writes=%0d left=%0d aborted=%b, want 2 2 0 0",
                         sent_cnt, count_kind(1), exp_q.size(), aborted);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_len = '0; cmd_abort = 1'b0;
    bus.src_valid = 1'b1; bus.src_data = 8'h41; bus.reg_ack = 1'b0; bus.reg_rdata = 8'h00;
    fork
      bus_monitor();
      byte_source();
    join_none
    test_reset();
    test_basic();
    test_refill();
    test_poll();
    test_abort();
    test_zero_len();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
